// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle between the execute-stage controller and the multiply/divide unit.
// The controller drives the master side; the unit implements the slave side.
interface mult_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            sel_hi;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            done;
  logic            div_zero;

  modport master (
    output start, op, rs_val, rt_val, sel_hi,
    input  rd_val, hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val, sel_hi,
    output rd_val, hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO registers; ITERS run cycles plus one sign-fix cycle.
// Optional MDU_MADD_EN enables op 111 (signed multiply-accumulate into {hi,lo}); otherwise op 111 is a NOP.
module mult_div_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = XLEN
) (
  input  logic           clk,
  input  logic           rst,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(ITERS);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_FIX  = 2'b10;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_MADD  = 3'b111;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d, madd_q, madd_d, done_q, done_d, dz_out_q, dz_out_d;

  logic              op_mul, op_div, op_signed, op_madd, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    op_madd = 1'b0;
`ifdef MDU_MADD_EN
    op_madd = (bus.op == OP_MADD);
`endif
    op_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU) || op_madd;
    op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV) || op_madd;
    a_neg     = op_signed && bus.rs_val[XLEN-1];
    b_neg     = op_signed && bus.rt_val[XLEN-1];
    a_mag     = a_neg ? -bus.rs_val : bus.rs_val;
    b_mag     = b_neg ? -bus.rt_val : bus.rt_val;
  end

  // Multiply keeps the multiplier in acc low half and shifts it out; divide shifts the dividend into the remainder.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (!is_div_q)
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    else if (rem_diff[XLEN])
      acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else
      acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    madd_d    = madd_q;
    done_d    = 1'b0;
    dz_out_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && (op_mul || op_div)) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          is_div_d  = op_div;
          madd_d    = op_madd;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = (bus.rt_val == '0);
          opnd_d    = op_div ? b_mag : a_mag;
          acc_d     = {{XLEN{1'b0}}, op_div ? a_mag : b_mag};
        end else if (bus.start && bus.op == OP_MTHI) begin
          hi_d = bus.rs_val;
        end else if (bus.start && bus.op == OP_MTLO) begin
          lo_d = bus.rs_val;
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITERS - 1))
          state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = dz_q ? {XLEN{1'b1}} : quo_fix;
        end else if (madd_q) begin
          {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d   = 1'b1;
        dz_out_d = is_div_q && dz_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      madd_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      madd_q    <= madd_d;
      done_q    <= done_d;
      dz_out_q  <= dz_out_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.rd_val   = bus.sel_hi ? hi_q : lo_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_out_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit against a plain-arithmetic model of HI/LO.
module tb_mult_div_unit;
  localparam int XLEN  = 32;
  localparam int ITERS = XLEN;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_MADD  = 3'b111;

  logic clk;
  logic rst;
  mult_div_unit_if #(.XLEN(XLEN)) mdu ();

  mult_div_unit #(.XLEN(XLEN), .ITERS(ITERS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] hi_m, lo_m;
  logic        dz_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from 64-bit integer arithmetic.
  task automatic model(input logic [2:0] op_v, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    dz_m = 1'b0;
    case (op_v)
      OP_MULT:  begin sp = sa * sb; {hi_m, lo_m} = sp; end
      OP_MULTU: begin up = 64'(a) * 64'(b); {hi_m, lo_m} = up; end
      OP_MADD:  begin sp = sa * sb; {hi_m, lo_m} = {hi_m, lo_m} + 64'(sp); end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          hi_m = a; lo_m = 32'hFFFFFFFF; dz_m = 1'b1;
        end else if (op_v == OP_DIV) begin
          sp = sa / sb; lo_m = sp[31:0];
          sp = sa % sb; hi_m = sp[31:0];
        end else begin
          lo_m = a / b; hi_m = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // Entered and left at a negedge; the done cycle is the exit point so a new op may start there.
  task automatic run_op(input logic [2:0] op_v, input logic [31:0] a, input logic [31:0] b,
                        input bit interfere, input int abort_at);
    logic [31:0] old_hi, old_lo;
    bit          sel;
    old_hi = hi_m;
    old_lo = lo_m;
    sel    = 1'($urandom_range(0, 1));
    mdu.start = 1'b1; mdu.op = op_v; mdu.rs_val = a; mdu.rt_val = b; mdu.sel_hi = sel;
    @(negedge clk);
    mdu.start = 1'b0; mdu.op = 3'($urandom); mdu.rs_val = $urandom; mdu.rt_val = $urandom;
    for (int k = 1; k <= ITERS + 1; k++) begin
      if (k == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        hi_m = '0; lo_m = '0;
        check("abort_busy", 32'(mdu.busy), 32'd0);
        check("abort_hi", mdu.hi, 32'd0);
        check("abort_lo", mdu.lo, 32'd0);
        for (int j = 0; j < ITERS + 4; j++) begin
          check("abort_done", 32'(mdu.done), 32'd0);
          @(negedge clk);
        end
        check("abort_lo_after", mdu.lo, 32'd0);
        return;
      end
      check("run_busy", 32'(mdu.busy), 32'd1);
      check("run_done", 32'(mdu.done), 32'd0);
      check("run_rd_val", mdu.rd_val, sel ? old_hi : old_lo);
      if (interfere && k == 5) begin
        mdu.start = 1'b1; mdu.op = OP_MTLO; mdu.rs_val = 32'hDEADBEEF;
      end else if (interfere && k == 6) begin
        mdu.start = 1'b0; mdu.rs_val = ~mdu.rs_val;
      end
      @(negedge clk);
    end
    model(op_v, a, b);
    check("fin_done", 32'(mdu.done), 32'd1);
    check("fin_busy", 32'(mdu.busy), 32'd0);
    check("fin_hi", mdu.hi, hi_m);
    check("fin_lo", mdu.lo, lo_m);
    check("fin_div_zero", 32'(mdu.div_zero), 32'(dz_m));
    check("fin_rd_val", mdu.rd_val, sel ? hi_m : lo_m);
  endtask

  task automatic mt(input bit to_hi, input logic [31:0] v);
    mdu.start = 1'b1; mdu.op = to_hi ? OP_MTHI : OP_MTLO; mdu.rs_val = v;
    @(negedge clk);
    mdu.start = 1'b0; mdu.op = 3'b000;
    if (to_hi) hi_m = v; else lo_m = v;
    check("mt_hi", mdu.hi, hi_m);
    check("mt_lo", mdu.lo, lo_m);
    check("mt_done", 32'(mdu.done), 32'd0);
    check("mt_busy", 32'(mdu.busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    rst = 1'b0;
    mdu.start = 1'b0; mdu.op = 3'b000; mdu.rs_val = '0; mdu.rt_val = '0; mdu.sel_hi = 1'b0;
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", mdu.hi, 32'd0);
    check("rst_lo", mdu.lo, 32'd0);
    check("rst_busy", 32'(mdu.busy), 32'd0);
    check("rst_done", 32'(mdu.done), 32'd0);
    check("rst_div_zero", 32'(mdu.div_zero), 32'd0);
    check("rst_rd_val", mdu.rd_val, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0, 0);
    check("mult_neg_hi", mdu.hi, 32'hFFFFFFFF);
    check("mult_neg_lo", mdu.lo, 32'hFFFFFFF1);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
    check("multu_max_hi", mdu.hi, 32'hFFFFFFFE);
    check("multu_max_lo", mdu.lo, 32'h00000001);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
    check("div_neg_lo", mdu.lo, 32'hFFFFFFFD);
    check("div_neg_hi", mdu.hi, 32'hFFFFFFFF);
    run_op(OP_DIVU, 32'h12345678, 32'd0, 1'b0, 0);
    check("divu_zero_hi", mdu.hi, 32'h12345678);
    check("divu_zero_flag", 32'(mdu.div_zero), 32'd1);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    check("div_ovf_lo", mdu.lo, 32'h80000000);
    check("div_ovf_hi", mdu.hi, 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(mdu.done), 32'd0);
    check("dz_one_cycle", 32'(mdu.div_zero), 32'd0);

    mt(1'b1, 32'hAAAA5555);
    mt(1'b0, 32'h0F0F0F0F);
    mdu.sel_hi = 1'b1;
    #1 check("rd_val_hi", mdu.rd_val, 32'hAAAA5555);

    run_op(OP_MULT, 32'd1234, 32'hFFFFF000, 1'b1, 0);
    run_op(OP_MULTU, 32'h0BADF00D, 32'd77, 1'b1, 10);

    mt(1'b1, 32'd0);
    mt(1'b0, 32'd10);
`ifdef MDU_MADD_EN
    run_op(OP_MADD, 32'd3, 32'd4, 1'b0, 0);
    check("madd_lo", mdu.lo, 32'd22);
    check("madd_hi", mdu.hi, 32'd0);
    run_op(OP_MADD, 32'hFFFFFFFF, 32'd100, 1'b0, 0);
`else
    mdu.start = 1'b1; mdu.op = OP_MADD; mdu.rs_val = 32'd3; mdu.rt_val = 32'd4;
    @(negedge clk);
    mdu.start = 1'b0; mdu.op = 3'b000;
    for (int j = 0; j < 3; j++) begin
      check("madd_off_busy", 32'(mdu.busy), 32'd0);
      check("madd_off_done", 32'(mdu.done), 32'd0);
      check("madd_off_lo", mdu.lo, 32'd10);
      check("madd_off_hi", mdu.hi, 32'd0);
      @(negedge clk);
    end
`endif

    for (int i = 0; i < 40; i++) begin
      a = pick();
      b = pick();
      case ($urandom_range(0, 5))
        0: run_op(OP_MULT, a, b, 1'b0, 0);
        1: run_op(OP_MULTU, a, b, 1'b0, 0);
        2: run_op(OP_DIV, a, b, 1'b0, 0);
        3: run_op(OP_DIVU, a, b, 1'b0, 0);
        4: mt(1'($urandom_range(0, 1)), a);
`ifdef MDU_MADD_EN
        default: run_op(OP_MADD, a, b, 1'b0, 0);
`else
        default: run_op(OP_DIV, a, b, 1'b1, 0);
`endif
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the execute stage.
- Consumes the register file's two read ports (RD1 → rs_val, RD2 → rt_val).
- Its MFHI/MFLO result is muxed onto the register file write-data path (WD3).
- Asserts busy so the controller can stall the PC and register-file writes during long operations.

Parameters:
- XLEN, 32, operand width; HI/LO are XLEN bits each; product is 2*XLEN.
- ITERS, XLEN, iteration cycles per MUL/DIV operation; must equal XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset: synchronous, active-low.
- start  in  1  op request strobe, sampled on clk edge.
- op  in  3  operation: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MADD (feature-gated).
- rs_val  in  XLEN  operand A (multiplicand / dividend / MT source).
- rt_val  in  XLEN  operand B (multiplier / divisor).
- sel_hi  in  1  1 selects HI, 0 selects LO onto rd_val.
- rd_val  out  XLEN  combinational HI or LO per sel_hi (MFHI/MFLO data to WD3).
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.
- busy  out  1  high while an accepted MUL/DIV is in progress.
- done  out  1  one-cycle pulse when HI/LO receive a MUL/DIV result.
- div_zero  out  1  one-cycle pulse coincident with done when the divisor was 0.

Behaviour:

Reset:
- Any edge with rst=0: state=IDLE; hi=lo=0; busy=done=div_zero=0; counter=0; partial result discarded.
- Applies mid-operation too: no HI/LO update occurs from the aborted op.

States and transitions:
- IDLE: busy=0.
  - start=1 with op MULT/MULTU/DIV/DIVU → latch operands (magnitudes for signed ops, sign flags saved), counter=0, go to RUN.
  - start=1 with MTHI/MTLO → write hi/lo from rs_val at that edge; stay IDLE; no done.
  - NOP → no effect.
- RUN: busy=1; exactly ITERS cycles.
  - Multiply: one shift-add step per cycle (radix-2) on the 2*XLEN accumulator.
  - Divide: one restoring shift-subtract step per cycle.
  - When counter reaches ITERS-1 → go to FIX.
- FIX: busy=1; one cycle.
  - Apply sign correction, then write hi/lo at the end of the cycle.
  - Go to IDLE with done=1 (and div_zero if applicable) registered for the next cycle.
- Latency: start edge at cycle 0; busy=1 in cycles 1..ITERS+1; in cycle ITERS+2, done=1, busy=0 and the new hi/lo are visible.

Arithmetic rules:
- MULT/MULTU: {hi,lo} = full 2*XLEN product, signed or unsigned.
- DIV/DIVU: lo = quotient, hi = remainder.
- Signed division truncates toward zero; the remainder takes the dividend's sign.
- Signed -2^31 / -1: lo=0x80000000, hi=0; no trap.
- Divisor 0 (DIV or DIVU): still runs the full latency; result hi=rs_val, lo=0xFFFFFFFF; div_zero=1 with done.

Boundary conditions:
- start while busy=1 is ignored entirely, including MTHI/MTLO; the controller must hold the request until busy=0.
- start in the same cycle that done=1 (state IDLE) is accepted normally.
- rd_val is always the current hi/lo. During busy it shows the pre-operation values; the controller stalls MFHI/MFLO on busy.
- Operands are latched at the start edge; later changes to rs_val/rt_val do not affect the result.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op 111 (MADD) is accepted like MULT. The signed product is added to {hi,lo} as a 2*XLEN sum with wraparound in the FIX cycle. Same latency, and done pulses.
- Not defined: op 111 is treated as NOP; no state change, busy stays 0.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 → after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high exactly cycles 1..33.
- MULTU rs=rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. DIV rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=0x12345678, rt=0 → hi=0x12345678, lo=0xFFFFFFFF, div_zero=1 with done. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0xAAAA5555 then MTLO 0x0F0F0F0F in IDLE → hi/lo updated next edge, done stays 0; sel_hi=1 → rd_val=0xAAAA5555.
- Start MULT, then pulse start with MTLO 0xDEADBEEF and toggle rs_val at cycle 5 → both ignored, result unchanged. Then drive rst=0 at cycle 10 → hi=lo=0, busy=0, no done pulse.
- With MDU_MADD_EN: hi=0, lo=10, MADD rs=3, rt=4 → lo=22, hi=0. Without the macro: same stimulus → busy stays 0, hi/lo unchanged.
